// File: rtl/ibuf_sync_filter.sv
// ibuf_sync_filter
//   Pad input conditioner. The asynchronous pad level I goes through a
//   SYNC_STAGES-deep synchronizer. The synchronized level S is accepted onto O
//   only after it has differed from O for FILTER_LEN consecutive edges while the
//   pad is released (T=1). RISE and FALL are registered one-cycle pulses that
//   mark each accepted change of O.
//
// Parameters
//   SYNC_STAGES  synchronizer depth, 2..4
//   FILTER_LEN   consecutive differing edges required to accept a change, 1..255
//   INIT         reset value of the synchronizer flops and of O
//
// Ports
//   C     clock, rising edge
//   CLR   asynchronous active-high reset
//   I     asynchronous pad input
//   T     tristate control of the paired driver (0 = driven, 1 = released)
//   O     filtered, synchronized pad level
//   RISE  one-cycle pulse on an accepted 0->1 change of O
//   FALL  one-cycle pulse on an accepted 1->0 change of O
module ibuf_sync_filter #(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILTER_LEN  = 4,
    parameter logic INIT        = 1'b0
) (
    input  logic C,
    input  logic CLR,
    input  logic I,
    input  logic T,
    output logic O,
    output logic RISE,
    output logic FALL
);

    localparam logic [7:0] CNT_LAST = 8'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [7:0]             cnt;

    assign s = sync[SYNC_STAGES-1];

    // The synchronizer keeps running while the driver is enabled, so S is
    // already settled when the pad is released again.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            sync <= {SYNC_STAGES{INIT}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], I};
        end
    end

    // cnt holds how many consecutive edges S has already differed from O.
    // The edge that would bring it to FILTER_LEN accepts the change instead,
    // so cnt tops out at FILTER_LEN-1 and never wraps. While the block drives
    // the pad (T=0) its own level is meaningless, so the count restarts.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            cnt  <= '0;
            O    <= INIT;
            RISE <= 1'b0;
            FALL <= 1'b0;
        end else begin
            RISE <= 1'b0;
            FALL <= 1'b0;
            if (!T || (s == O)) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt  <= '0;
                O    <= s;
                RISE <= s;
                FALL <= ~s;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ibuf_sync_filter.sv
module tb_ibuf_sync_filter;

    logic       C = 1'b0;
    logic       CLR;
    logic       I;
    logic       T;
    logic [3:0] o, rise, fall;

    int checks = 0;
    int errors = 0;

    always #5 C = ~C;

    // Four configurations share the same stimulus.
    ibuf_sync_filter #(.SYNC_STAGES(2), .FILTER_LEN(4), .INIT(1'b0)) u0 (
        .C(C), .CLR(CLR), .I(I), .T(T), .O(o[0]), .RISE(rise[0]), .FALL(fall[0]));
    ibuf_sync_filter #(.SYNC_STAGES(2), .FILTER_LEN(1), .INIT(1'b0)) u1 (
        .C(C), .CLR(CLR), .I(I), .T(T), .O(o[1]), .RISE(rise[1]), .FALL(fall[1]));
    ibuf_sync_filter #(.SYNC_STAGES(2), .FILTER_LEN(4), .INIT(1'b1)) u2 (
        .C(C), .CLR(CLR), .I(I), .T(T), .O(o[2]), .RISE(rise[2]), .FALL(fall[2]));
    ibuf_sync_filter #(.SYNC_STAGES(4), .FILTER_LEN(7), .INIT(1'b1)) u3 (
        .C(C), .CLR(CLR), .I(I), .T(T), .O(o[3]), .RISE(rise[3]), .FALL(fall[3]));

    // Reference model: a pure delay line for S and a run length of
    // consecutive released edges on which S disagreed with O.
    int         ss[4]  = '{2, 2, 2, 4};
    int         fl[4]  = '{4, 1, 4, 7};
    logic       ini[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] m_sq[4];
    logic       m_o[4], m_r[4], m_f[4];
    int         m_run[4];

    task automatic model_reset();
        for (int j = 0; j < 4; j++) begin
            m_sq[j]  = {4{ini[j]}};
            m_o[j]   = ini[j];
            m_r[j]   = 1'b0;
            m_f[j]   = 1'b0;
            m_run[j] = 0;
        end
    endtask

    // One rising edge: advance the model with the pre-edge inputs, then
    // return 1 time unit later so outputs can be sampled off the edge.
    task automatic tick();
        logic s_old;
        @(posedge C);
        if (!CLR) begin
            for (int j = 0; j < 4; j++) begin
                s_old   = m_sq[j][ss[j]-1];
                m_r[j]  = 1'b0;
                m_f[j]  = 1'b0;
                if (T && (s_old != m_o[j])) m_run[j]++;
                else                        m_run[j] = 0;
                if (m_run[j] == fl[j]) begin
                    m_o[j]   = s_old;
                    m_r[j]   = s_old;
                    m_f[j]   = ~s_old;
                    m_run[j] = 0;
                end
                m_sq[j] = {m_sq[j][2:0], I};
            end
        end
        #1;
    endtask

    task automatic test_reset();
        CLR = 1'b1; I = 1'b0; T = 1'b1;
        model_reset();
        repeat (3) begin
            tick();
            for (int j = 0; j < 4; j++) begin
                checks++;
                if ({o[j], rise[j], fall[j]} !== {ini[j], 2'b00}) begin
                    errors++;
                    $display("FAIL reset dut%0d: O/R/F=%b%b%b expected %b00", j, o[j], rise[j], fall[j], ini[j]);
                end
            end
        end
        #2 CLR = 1'b0;
        // I=0 through reset: INIT=1 instances must produce a FALL after release.
        repeat (14) begin
            tick();
            for (int j = 0; j < 4; j++) begin
                checks++;
                if ({o[j], rise[j], fall[j]} !== {m_o[j], m_r[j], m_f[j]}) begin
                    errors++;
                    $display("FAIL release dut%0d: O/R/F=%b%b%b expected %b%b%b", j, o[j], rise[j], fall[j], m_o[j], m_r[j], m_f[j]);
                end
            end
        end
    endtask

    task automatic test_latency();
        I = 1'b1;
        // e=1 is the first edge sampling I=1: S at e=2, O/RISE at e=6.
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 5 || e == 6 || e == 7) begin
                checks++;
                if ({o[0], rise[0]} !== {(e >= 6) ? 1'b1 : 1'b0, (e == 6) ? 1'b1 : 1'b0}) begin
                    errors++;
                    $display("FAIL latency edge %0d: O/RISE=%b%b", e, o[0], rise[0]);
                end
            end
            for (int j = 0; j < 4; j++) begin
                checks++;
                if ({o[j], rise[j], fall[j]} !== {m_o[j], m_r[j], m_f[j]}) begin
                    errors++;
                    $display("FAIL latency dut%0d: O/R/F=%b%b%b expected %b%b%b", j, o[j], rise[j], fall[j], m_o[j], m_r[j], m_f[j]);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        I = 1'b0;
        repeat (14) tick();
        I = 1'b1;
        repeat (3) tick();
        I = 1'b0;
        repeat (3) tick();
        for (int c = 0; c < 12; c++) begin
            if (c > 0) tick();
            if (rise[0] || fall[0]) pulses++;
            for (int j = 0; j < 4; j++) begin
                checks++;
                if ({o[j], rise[j], fall[j]} !== {m_o[j], m_r[j], m_f[j]}) begin
                    errors++;
                    $display("FAIL glitch dut%0d: O/R/F=%b%b%b expected %b%b%b", j, o[j], rise[j], fall[j], m_o[j], m_r[j], m_f[j]);
                end
            end
        end
        checks++;
        if (o[0] !== 1'b0 || pulses != 0) begin
            errors++;
            $display("FAIL glitch_quiet: O=%b pulses=%0d expected O=0 pulses=0", o[0], pulses);
        end
    endtask

    task automatic test_tristate();
        I = 1'b1; T = 1'b1;
        repeat (14) tick();
        I = 1'b0; T = 1'b0;
        repeat (10) begin
            tick();
            for (int j = 0; j < 4; j++) begin
                checks++;
                if ({o[j], rise[j], fall[j]} !== {1'b1, 2'b00}) begin
                    errors++;
                    $display("FAIL tristate_hold dut%0d: O/R/F=%b%b%b expected 100", j, o[j], rise[j], fall[j]);
                end
            end
        end
        T = 1'b1;
        repeat (10) begin
            tick();
            for (int j = 0; j < 4; j++) begin
                checks++;
                if ({o[j], rise[j], fall[j]} !== {m_o[j], m_r[j], m_f[j]}) begin
                    errors++;
                    $display("FAIL tristate_release dut%0d: O/R/F=%b%b%b expected %b%b%b", j, o[j], rise[j], fall[j], m_o[j], m_r[j], m_f[j]);
                end
            end
        end
    endtask

    task automatic test_clr_midcount();
        I = 1'b0; T = 1'b1;
        repeat (12) tick();
        I = 1'b1;
        repeat (4) tick();   // u0 now two edges into its count
        #2 CLR = 1'b1;
        #1 model_reset();
        for (int j = 0; j < 4; j++) begin
            checks++;
            if ({o[j], rise[j], fall[j]} !== {ini[j], 2'b00}) begin
                errors++;
                $display("FAIL clr_async dut%0d: O/R/F=%b%b%b expected %b00", j, o[j], rise[j], fall[j], ini[j]);
            end
        end
        #2 CLR = 1'b0;
        repeat (14) begin
            tick();
            for (int j = 0; j < 4; j++) begin
                checks++;
                if ({o[j], rise[j], fall[j]} !== {m_o[j], m_r[j], m_f[j]}) begin
                    errors++;
                    $display("FAIL clr_midcount dut%0d: O/R/F=%b%b%b expected %b%b%b", j, o[j], rise[j], fall[j], m_o[j], m_r[j], m_f[j]);
                end
            end
        end
    endtask

    task automatic test_filter1();
        int rises = 0, falls = 0;
        for (int c = 0; c < 30; c++) begin
            if (c % 3 == 0) I = ~I;
            tick();
            rises += int'(rise[1]);
            falls += int'(fall[1]);
            for (int j = 0; j < 4; j++) begin
                checks++;
                if ({o[j], rise[j], fall[j]} !== {m_o[j], m_r[j], m_f[j]}) begin
                    errors++;
                    $display("FAIL filter1 dut%0d: O/R/F=%b%b%b expected %b%b%b", j, o[j], rise[j], fall[j], m_o[j], m_r[j], m_f[j]);
                end
            end
        end
        checks++;
        if (rises < 4 || falls < 4) begin
            errors++;
            $display("FAIL filter1_pulses: rises=%0d falls=%0d expected >=4 each", rises, falls);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0)  I = ~I;
            if ($urandom_range(15) == 0) T = ~T;
            if ($urandom_range(199) == 0) begin
                #2 CLR = 1'b1;
                #1 model_reset();
                #1 CLR = 1'b0;
            end
            tick();
            for (int j = 0; j < 4; j++) begin
                checks++;
                if ({o[j], rise[j], fall[j]} !== {m_o[j], m_r[j], m_f[j]} || (rise[j] && fall[j])) begin
                    errors++;
                    $display("FAIL random dut%0d cyc %0d: O/R/F=%b%b%b expected %b%b%b", j, c, o[j], rise[j], fall[j], m_o[j], m_r[j], m_f[j]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_tristate();
        test_clr_midcount();
        test_filter1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
